// File: rtl/quad_encoder_if.sv
// Host-side bundle for the quadrature transmitter: delta strobe and controls in,
// A/B phases and accumulator status out.
interface quad_encoder_if #(
    parameter int DELTA_W = 9,
    parameter int ACC_W   = 12
);
    logic                      delta_valid;
    logic signed [DELTA_W-1:0] delta;
    logic                      enable;
    logic                      clear;
    logic                      A;
    logic                      B;
    logic                      busy;
    logic signed [ACC_W-1:0]   pending;
    logic                      ovf;

    modport master (
        output delta_valid, delta, enable, clear,
        input  A, B, busy, pending, ovf
    );

    modport slave (
        input  delta_valid, delta, enable, clear,
        output A, B, busy, pending, ovf
    );
endinterface

// File: rtl/quad_encoder.sv
// Quadrature transmitter: accumulates signed edge deltas and paces them out as
// Gray-coded A/B edges, one edge every STEP_DIV clocks.
module quad_encoder #(
    parameter int DELTA_W  = 9,
    parameter int ACC_W    = 12,
    parameter int STEP_DIV = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    quad_encoder_if.slave bus
);
    localparam int TW  = $clog2(STEP_DIV);
    localparam int SW  = ((ACC_W > DELTA_W) ? ACC_W : DELTA_W) + 2;
    localparam int LIM = 2 ** (ACC_W - 1) - 1;

    localparam logic [TW-1:0]        TIMER_LAST = TW'(STEP_DIV - 1);
    localparam logic signed [SW-1:0] LIM_POS    = SW'(LIM);
    localparam logic signed [SW-1:0] LIM_NEG    = SW'(-LIM);

    logic signed [ACC_W-1:0] acc_reg, acc_next;
    logic [TW-1:0]           timer_reg, timer_next;
    logic                    a_reg, a_next;
    logic                    b_reg, b_next;
    logic                    busy_reg, busy_next;
    logic                    ovf_reg, ovf_next;

    logic                    acc_nz;
    logic                    step_due;
    logic                    step_neg;
    logic signed [SW-1:0]    add_term;
    logic signed [SW-1:0]    step_term;
    logic signed [SW-1:0]    sum;

    always_comb begin
        acc_nz     = (acc_reg != '0);
        step_due   = bus.enable && acc_nz && (timer_reg == TIMER_LAST);
        step_neg   = acc_reg[ACC_W-1];
        add_term   = bus.delta_valid ? SW'(bus.delta) : '0;
        step_term  = '0;
        if (step_due) begin
            step_term = step_neg ? {SW{1'b1}} : SW'(1);
        end
        sum        = SW'(acc_reg) + add_term - step_term;

        // Saturate symmetrically so the most-negative code never appears.
        acc_next   = sum[ACC_W-1:0];
        ovf_next   = 1'b0;
        if (sum > LIM_POS) begin
            acc_next = ACC_W'(LIM);
            ovf_next = 1'b1;
        end else if (sum < LIM_NEG) begin
            acc_next = ACC_W'(-LIM);
            ovf_next = 1'b1;
        end

        timer_next = '0;
        if (bus.enable && acc_nz && !step_due) begin
            timer_next = timer_reg + TW'(1);
        end

        // Forward walks 00->10->11->01; reverse walks it backwards.
        a_next     = a_reg;
        b_next     = b_reg;
        if (step_due) begin
            if (step_neg) begin
                a_next = b_reg;
                b_next = ~a_reg;
            end else begin
                a_next = ~b_reg;
                b_next = a_reg;
            end
        end

        if (bus.clear) begin
            acc_next   = '0;
            timer_next = '0;
            ovf_next   = 1'b0;
            a_next     = a_reg;
            b_next     = b_reg;
        end

        busy_next  = (acc_next != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_reg   <= '0;
            timer_reg <= '0;
            a_reg     <= 1'b0;
            b_reg     <= 1'b0;
            busy_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            acc_reg   <= acc_next;
            timer_reg <= timer_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            busy_reg  <= busy_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign bus.A       = a_reg;
    assign bus.B       = b_reg;
    assign bus.busy    = busy_reg;
    assign bus.pending = acc_reg;
    assign bus.ovf     = ovf_reg;
endmodule

// File: tb/tb_quad_encoder.sv
// Scoreboard bench: each stimulus pushes the A/B edges it should cause; the
// monitor pops and compares every edge the encoder actually produces.
module tb_quad_encoder;
    localparam int DW  = 9;
    localparam int AW  = 12;
    localparam int AWS = 4;
    localparam int SD  = 4;

    typedef struct {
        logic [1:0] ab;
        int         pend;
        int         cyc;
    } sb_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    quad_encoder_if #(.DELTA_W(DW), .ACC_W(AW))  bus ();
    quad_encoder_if #(.DELTA_W(DW), .ACC_W(AWS)) s_bus ();

    quad_encoder #(.DELTA_W(DW), .ACC_W(AW), .STEP_DIV(SD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    quad_encoder #(.DELTA_W(DW), .ACC_W(AWS), .STEP_DIV(SD)) dut_s (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (s_bus)
    );

    logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    sb_t        sb [$];
    sb_t        mon_e;
    logic [1:0] mon_cur;
    logic [1:0] prev_ab = 2'b00;
    logic [1:0] s_prev  = 2'b00;
    int         errors  = 0;
    int         checks  = 0;
    int         cyc     = 0;
    int         exp_idx = 0;
    int         dec_cnt = 0;
    int         s_edges = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int idx_of(input logic [1:0] ab);
        int r = 0;
        for (int i = 0; i < 4; i++) if (seq[i] == ab) r = i;
        return r;
    endfunction

    // Main DUT monitor: every A/B change is one scoreboard transaction.
    always @(negedge clk) begin
        mon_cur = {bus.A, bus.B};
        if (!reset_n) begin
            prev_ab = mon_cur;
        end else if (mon_cur != prev_ab) begin
            check_eq("single_toggle", int'((mon_cur ^ prev_ab) == 2'b11), 0);
            if (seq[(idx_of(prev_ab) + 1) % 4] == mon_cur) dec_cnt++;
            else dec_cnt--;
            if (sb.size() == 0) begin
                check_eq("unexpected_edge", int'(mon_cur), int'(prev_ab));
            end else begin
                mon_e = sb.pop_front();
                $display("edge cyc=%0d ab=%b pending=%0d", cyc, mon_cur, int'(bus.pending));
                check_eq("edge_ab", int'(mon_cur), int'(mon_e.ab));
                check_eq("edge_pending", int'(bus.pending), mon_e.pend);
                check_eq("edge_cycle", cyc, mon_e.cyc);
            end
            prev_ab = mon_cur;
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            s_prev = {s_bus.A, s_bus.B};
        end else if ({s_bus.A, s_bus.B} != s_prev) begin
            s_edges++;
            s_prev = {s_bus.A, s_bus.B};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int d, output int n);
        bus.delta       = DW'(d);
        bus.delta_valid = 1'b1;
        tick();
        bus.delta_valid = 1'b0;
        bus.delta       = '0;
        n               = cyc;
    endtask

    // Expected edges: cnt steps in direction dir, strobe sampled at edge cyc0,
    // pending after step k is pend0 - dir*k, edge k lands at cyc0 + SD*k.
    task automatic push_steps(input int dir, input int cnt, input int pend0, input int cyc0);
        sb_t e;
        for (int k = 1; k <= cnt; k++) begin
            exp_idx = (exp_idx + dir + 4) % 4;
            e.ab    = seq[exp_idx];
            e.pend  = pend0 - dir * k;
            e.cyc   = cyc0 + SD * k;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input string tag, input int max_cyc);
        int k = 0;
        while (sb.size() != 0 && k < max_cyc) begin
            tick();
            k++;
        end
        check_eq(tag, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;
        int base;
        bus.delta_valid   = 1'b0;
        bus.delta         = '0;
        bus.enable        = 1'b1;
        bus.clear         = 1'b0;
        s_bus.delta_valid = 1'b0;
        s_bus.delta       = '0;
        s_bus.enable      = 1'b1;
        s_bus.clear       = 1'b0;

        repeat (2) tick();
        check_eq("rst_A", int'(bus.A), 0);
        check_eq("rst_B", int'(bus.B), 0);
        check_eq("rst_busy", int'(bus.busy), 0);
        check_eq("rst_pending", int'(bus.pending), 0);
        check_eq("rst_ovf", int'(bus.ovf), 0);
        reset_n = 1'b1;
        tick();

        // +3: 10, 11, 01 at +4, +8, +12
        strobe(3, n);
        check_eq("p3_pending", int'(bus.pending), 3);
        check_eq("p3_busy", int'(bus.busy), 1);
        push_steps(1, 3, 3, n);
        drain("p3_drain", 40);
        check_eq("p3_busy_end", int'(bus.busy), 0);

        strobe(1, n);
        push_steps(1, 1, 1, n);
        drain("p1_drain", 20);

        // -2 from 00: 01 then 11
        strobe(-2, n);
        check_eq("m2_pending", int'(bus.pending), -2);
        push_steps(-1, 2, -2, n);
        drain("m2_drain", 30);

        // Reset mid-stream: phases return to 00 without waiting for a clock
        strobe(3, n);
        push_steps(1, 1, 3, n);
        drain("rst_mid_drain", 20);
        check_eq("rst_mid_pre_A", int'(bus.A), 0);
        check_eq("rst_mid_pre_B", int'(bus.B), 1);
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_A", int'(bus.A), 0);
        check_eq("rst_mid_B", int'(bus.B), 0);
        check_eq("rst_mid_pending", int'(bus.pending), 0);
        check_eq("rst_mid_busy", int'(bus.busy), 0);
        tick();
        reset_n = 1'b1;
        exp_idx = 0;
        tick();

        // +1 arriving on the cycle a step fires keeps pending at 5
        strobe(5, n);
        push_steps(1, 6, 6, n);
        repeat (3) tick();
        strobe(1, m);
        check_eq("coinc_cycle", m, n + SD);
        check_eq("coinc_pending", int'(bus.pending), 5);
        drain("coinc_drain", 60);

        // Sign reversal before first step: two negative edges only
        strobe(4, n);
        strobe(-6, m);
        check_eq("rev_pending", int'(bus.pending), -2);
        push_steps(-1, 2, -2, n);
        drain("rev_drain", 30);

        // enable=0 freezes A/B but keeps accumulating
        bus.enable = 1'b0;
        strobe(2, n);
        repeat (6) tick();
        check_eq("en0_pending", int'(bus.pending), 2);
        check_eq("en0_busy", int'(bus.busy), 1);
        check_eq("en0_ab", int'({bus.A, bus.B}), int'(seq[exp_idx]));
        push_steps(1, 2, 2, cyc);
        bus.enable = 1'b1;
        tick();
        drain("en1_drain", 30);

        // clear beats a simultaneous delta and holds the phase
        strobe(5, n);
        push_steps(1, 1, 5, n);
        repeat (5) tick();
        bus.clear       = 1'b1;
        bus.delta_valid = 1'b1;
        bus.delta       = DW'(7);
        tick();
        bus.clear       = 1'b0;
        bus.delta_valid = 1'b0;
        bus.delta       = '0;
        check_eq("clr_pending", int'(bus.pending), 0);
        check_eq("clr_busy", int'(bus.busy), 0);
        check_eq("clr_ab", int'({bus.A, bus.B}), int'(seq[exp_idx]));
        repeat (12) tick();
        check_eq("clr_no_edges", sb.size(), 0);
        check_eq("clr_pending_late", int'(bus.pending), 0);

        // Loopback: +100 twice decodes to a count of 100 in counter[8:1]
        base = dec_cnt;
        strobe(100, n);
        strobe(100, m);
        check_eq("loop_pending", int'(bus.pending), 200);
        push_steps(1, 200, 200, n);
        drain("loop_drain", 900);
        check_eq("loop_count", ((dec_cnt - base) >>> 1) & 255, 100);

        // Saturation on the 4-bit accumulator instance
        s_bus.delta       = DW'(20);
        s_bus.delta_valid = 1'b1;
        tick();
        s_bus.delta_valid = 1'b0;
        s_bus.delta       = '0;
        $display("sat strobe +20 pending=%0d ovf=%0d", int'(s_bus.pending), int'(s_bus.ovf));
        check_eq("sat_pos_pending", int'(s_bus.pending), 7);
        check_eq("sat_pos_ovf", int'(s_bus.ovf), 1);
        base = s_edges;
        tick();
        check_eq("sat_ovf_pulse", int'(s_bus.ovf), 0);
        repeat (40) tick();
        check_eq("sat_edges", s_edges - base, 7);
        check_eq("sat_drained", int'(s_bus.pending), 0);
        s_bus.delta       = DW'(-20);
        s_bus.delta_valid = 1'b1;
        tick();
        s_bus.delta_valid = 1'b0;
        s_bus.delta       = '0;
        $display("sat strobe -20 pending=%0d ovf=%0d", int'(s_bus.pending), int'(s_bus.ovf));
        check_eq("sat_neg_pending", int'(s_bus.pending), -7);
        check_eq("sat_neg_ovf", int'(s_bus.ovf), 1);
        s_bus.clear = 1'b1;
        tick();
        s_bus.clear = 1'b0;
        check_eq("sat_clr_pending", int'(s_bus.pending), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
